// File: rtl/store_merge_unit.sv
// Store path into word-addressed data memory: full-word stores write directly,
// byte/half stores read the containing word, merge the lane little-endian, and write it back.
//
// state | meaning
// IDLE  | ready for a request
// READ  | one-cycle read strobe for the containing word
// WAIT  | holding until read data returns
// WRITE | one-cycle write strobe with the final word
// DONE  | completion pulse
// ERR   | completion pulse flagged as misaligned/illegal, no memory access
module store_merge_unit (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [1:0]  req_op,
    output logic [31:0] mem_addr,
    output logic        mem_rd_en,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic        mem_wr_en,
    output logic [31:0] mem_wdata,
    output logic        done,
    output logic        misaligned
);

    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE, ERR} stateT;

    localparam logic [1:0] OP_HALF = 2'b00;
    localparam logic [1:0] OP_BYTE = 2'b01;
    localparam logic [1:0] OP_WORD = 2'b10;

    stateT       state;
    stateT       nextState;
    logic [31:0] addrReg;
    logic [1:0]  laneSel;
    logic [1:0]  capOp;
    logic [31:0] wordBuf;
    logic [31:0] mergedWord;
    logic        accept;
    logic        illegal;

    assign accept = req_valid && (state == IDLE);

    always_comb begin
        illegal = 1'b0;
        case (req_op)
            OP_HALF: illegal = req_addr[0];
            OP_BYTE: illegal = 1'b0;
            OP_WORD: illegal = (req_addr[1:0] != 2'b00);
            default: illegal = 1'b1;
        endcase
    end

    // wordBuf holds the store data until the read returns, then the merged word
    always_comb begin
        mergedWord = mem_rdata;
        if (capOp == OP_BYTE) begin
            case (laneSel)
                2'd0:    mergedWord[7:0]   = wordBuf[7:0];
                2'd1:    mergedWord[15:8]  = wordBuf[7:0];
                2'd2:    mergedWord[23:16] = wordBuf[7:0];
                default: mergedWord[31:24] = wordBuf[7:0];
            endcase
        end else if (capOp == OP_HALF) begin
            if (laneSel[1]) begin
                mergedWord[31:16] = wordBuf[15:0];
            end else begin
                mergedWord[15:0] = wordBuf[15:0];
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            addrReg <= '0;
            laneSel <= '0;
            capOp   <= '0;
            wordBuf <= '0;
        end else begin
            state <= nextState;
            if (accept) begin
                addrReg <= {req_addr[31:2], 2'b00};
                laneSel <= req_addr[1:0];
                capOp   <= req_op;
                wordBuf <= req_data;
            end else if (state == WAIT && mem_rvalid) begin
                wordBuf <= mergedWord;
            end
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (illegal) begin
                        nextState = ERR;
                    end else if (req_op == OP_WORD) begin
                        nextState = WRITE;
                    end else begin
                        nextState = READ;
                    end
                end
            end
            READ:    nextState = WAIT;
            WAIT:    nextState = mem_rvalid ? WRITE : WAIT;
            WRITE:   nextState = DONE;
            DONE:    nextState = IDLE;
            ERR:     nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    assign req_ready  = (state == IDLE);
    assign mem_addr   = addrReg;
    assign mem_rd_en  = (state == READ);
    assign mem_wr_en  = (state == WRITE);
    assign mem_wdata  = (state == WRITE) ? wordBuf : 32'h0;
    assign done       = (state == DONE) || (state == ERR);
    assign misaligned = (state == ERR);

endmodule

// File: tb/tb_store_merge_unit.sv
// Self-checking bench for store_merge_unit: a byte-array memory model predicts the
// per-cycle outputs for directed and randomized stores, including reset in WAIT.
module tb_store_merge_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_op;
    logic [31:0] mem_addr;
    logic        mem_rd_en;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        mem_wr_en;
    logic [31:0] mem_wdata;
    logic        done;
    logic        misaligned;

    store_merge_unit dut (
        .Clk(Clk), .Reset(Reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_op(req_op),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
        .done(done), .misaligned(misaligned)
    );

    always #5 Clk = ~Clk;

    int nChecks = 0;
    int nErrors = 0;
    int wrCount = 0;
    logic [31:0] lastWrData = '0;
    logic [31:0] memArr [logic [29:0]];
    logic [31:0] lastAddr = '0;
    logic checkEn = 1'b0;
    logic expReady, expRd, expWr, expDone, expMis;
    logic [31:0] expAddr, expWdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (mem_wr_en === 1'b1) begin
            wrCount++;
            lastWrData = mem_wdata;
        end
        if (checkEn) begin
            chk("req_ready", {31'b0, req_ready}, {31'b0, expReady});
            chk("mem_rd_en", {31'b0, mem_rd_en}, {31'b0, expRd});
            chk("mem_wr_en", {31'b0, mem_wr_en}, {31'b0, expWr});
            chk("done", {31'b0, done}, {31'b0, expDone});
            chk("misaligned", {31'b0, misaligned}, {31'b0, expMis});
            chk("mem_addr", mem_addr, expAddr);
            chk("mem_wdata", mem_wdata, expWdata);
        end
    end

    function automatic logic [31:0] memRead(input logic [29:0] w);
        if (!memArr.exists(w)) memArr[w] = $urandom;
        return memArr[w];
    endfunction

    function automatic logic [31:0] mergeModel(input logic [1:0] op, input logic [31:0] addr,
                                               input logic [31:0] data, input logic [31:0] old);
        logic [7:0] b [4];
        int base;
        for (int i = 0; i < 4; i++) b[i] = old[8*i +: 8];
        if (op == 2'b01) begin
            b[addr[1:0]] = data[7:0];
        end else begin
            base = addr[1] ? 2 : 0;
            b[base]     = data[7:0];
            b[base + 1] = data[15:8];
        end
        return {b[3], b[2], b[1], b[0]};
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idleExp();
        expReady = 1'b1; expRd = 1'b0; expWr = 1'b0; expDone = 1'b0; expMis = 1'b0;
        expAddr = lastAddr; expWdata = '0;
    endtask

    task automatic busyExp(input logic rd, input logic wr, input logic dn, input logic mis,
                           input logic [31:0] wd);
        expReady = 1'b0; expRd = rd; expWr = wr; expDone = dn; expMis = mis;
        expAddr = lastAddr; expWdata = wd;
    endtask

    task automatic randReq(input bit holdValid);
        req_valid = holdValid ? 1'b1 : 1'($urandom_range(0, 1));
        req_addr  = $urandom;
        req_data  = $urandom;
        req_op    = 2'($urandom_range(0, 3));
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            req_valid  = 1'b0;
            req_addr   = $urandom;
            req_data   = $urandom;
            req_op     = 2'($urandom_range(0, 3));
            mem_rvalid = 1'($urandom_range(0, 1));
            mem_rdata  = $urandom;
            idleExp();
        end
    endtask

    // d = cycles from the read strobe to rvalid (>= 1)
    task automatic doTxn(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data,
                         input int d, input bit junkRead, input bit holdValid);
        logic        bad;
        logic [29:0] w;
        logic [31:0] newWord;
        step();
        req_valid  = 1'b1;
        req_op     = op;
        req_addr   = addr;
        req_data   = data;
        mem_rvalid = 1'($urandom_range(0, 1));
        mem_rdata  = $urandom;
        idleExp();
        bad = (op == 2'b11) || (op == 2'b00 && addr[0]) || (op == 2'b10 && addr[1:0] != 2'b00);
        w = addr[31:2];
        lastAddr = {w, 2'b00};
        step();
        randReq(holdValid);
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        if (bad) begin
            busyExp(0, 0, 1, 1, '0);
        end else if (op == 2'b10) begin
            busyExp(0, 1, 0, 0, data);
            memArr[w] = data;
            step();
            randReq(holdValid);
            busyExp(0, 0, 1, 0, '0);
        end else begin
            newWord = mergeModel(op, addr, data, memRead(w));
            busyExp(1, 0, 0, 0, '0);
            mem_rvalid = junkRead;
            for (int k = 2; k <= 1 + d; k++) begin
                step();
                randReq(holdValid);
                busyExp(0, 0, 0, 0, '0);
                mem_rvalid = (k == 1 + d);
                mem_rdata  = (k == 1 + d) ? memRead(w) : $urandom;
            end
            step();
            randReq(holdValid);
            busyExp(0, 1, 0, 0, newWord);
            mem_rvalid = 1'($urandom_range(0, 1));
            mem_rdata  = $urandom;
            memArr[w] = newWord;
            step();
            randReq(holdValid);
            busyExp(0, 0, 1, 0, '0);
        end
    endtask

    initial begin
        int wrBefore;
        logic [31:0] a;
        Reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0; req_op = '0;
        mem_rdata = '0; mem_rvalid = 1'b0;
        #12;
        chk("reset req_ready", {31'b0, req_ready}, 32'd1);
        chk("reset mem_addr", mem_addr, 32'h0);
        chk("reset strobes", {28'b0, mem_rd_en, mem_wr_en, done, misaligned}, 32'h0);
        @(posedge Clk); #1;
        Reset = 1'b0;
        idleExp();
        checkEn = 1'b1;

        memArr[30'h40] = 32'hAABBCCDD;
        doTxn(2'b01, 32'h102, 32'h0000_0011, 1, 0, 0);
        chk("byte lane2", lastWrData, 32'hAA11CCDD);
        memArr[30'h40] = 32'hAABBCCDD;
        doTxn(2'b00, 32'h102, 32'h1234_5678, 1, 1, 0);
        chk("half upper", lastWrData, 32'h5678CCDD);
        memArr[30'h40] = 32'hAABBCCDD;
        doTxn(2'b00, 32'h100, 32'h0000_BEEF, 2, 0, 0);
        chk("half lower", lastWrData, 32'hAABBBEEF);
        doTxn(2'b10, 32'h104, 32'hDEAD_BEEF, 1, 0, 0);
        chk("word", lastWrData, 32'hDEADBEEF);
        wrBefore = wrCount;
        doTxn(2'b00, 32'h101, 32'h1111_1111, 1, 0, 0);
        doTxn(2'b10, 32'h102, 32'h2222_2222, 1, 0, 0);
        doTxn(2'b11, 32'h100, 32'h3333_3333, 1, 0, 0);
        idleCycles(1);
        chk("illegal no write", wrCount, wrBefore);
        memArr[30'h40] = 32'hAABBCCDD;
        doTxn(2'b01, 32'h101, 32'h0000_0077, 5, 1, 0);
        chk("byte delayed", lastWrData, 32'hAABB77DD);

        memArr[30'h42] = 32'h01020304;
        doTxn(2'b01, 32'h108, 32'h0000_00AA, 1, 0, 1);
        chk("b2b first", lastWrData, 32'h010203AA);
        doTxn(2'b01, 32'h10B, 32'h0000_00BB, 2, 0, 1);
        chk("b2b second", lastWrData, 32'hBB0203AA);

        // reset while waiting for read data
        wrBefore = wrCount;
        step();
        req_valid = 1'b1; req_op = 2'b01; req_addr = 32'h100; req_data = 32'h55;
        mem_rvalid = 1'b0;
        idleExp();
        lastAddr = 32'h100;
        step();
        req_valid = 1'b0;
        busyExp(1, 0, 0, 0, '0);
        step();
        busyExp(0, 0, 0, 0, '0);
        #2;
        checkEn = 1'b0;
        Reset = 1'b1;
        #1;
        chk("mid reset req_ready", {31'b0, req_ready}, 32'd1);
        chk("mid reset mem_addr", mem_addr, 32'h0);
        chk("mid reset wdata", mem_wdata, 32'h0);
        chk("mid reset strobes", {28'b0, mem_rd_en, mem_wr_en, done, misaligned}, 32'h0);
        step();
        step();
        Reset = 1'b0;
        lastAddr = '0;
        idleExp();
        checkEn = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_FFFF;
        idleCycles(4);
        chk("no write after reset", wrCount, wrBefore);

        for (int n = 0; n < 150; n++) begin
            a = 32'h200 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
            doTxn(2'($urandom_range(0, 3)), a, $urandom, $urandom_range(1, 4),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idleCycles($urandom_range(1, 2));
        end

        step();
        checkEn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
